uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 Uart8 rx path. Adds:
- configurable data width, parity mode and stop-bit count
- 16x oversampling with 3-sample majority vote
- start-bit glitch rejection
- separate parity, framing and break status

Sits between the board rx pin and the byte consumer. Same rx handshake signals as Uart8, plus extended status.

---
 rtl/uart_rx_cfg.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority vote, start-glitch
// rejection, configurable data width / parity / stop bits, with parity, framing and break status.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParErr,
  output logic                 rxFrameErr,
  output logic                 rxBreak,
  output logic [DATA_BITS-1:0] rxOut
);

  localparam int unsigned DIV     = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int unsigned DIV_EFF = (DIV == 0) ? 1 : DIV;
  localparam int unsigned DIV_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state, state_next;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_prev, fall, start_c;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [3:0]           s_cnt, s_next;
  logic                 mid, bit_end;
  logic [1:0]           samp;
  logic                 maj;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 last_data, last_stop;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_err, frm_err, par_exp, frm_fin;
  logic                 done_c, busy_c;

  // Two-flop synchroniser plus edge history, idling high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rxIn};
      rx_prev <= sync_q[1];
    end
  end

  assign rx_s    = sync_q[1];
  assign fall    = rx_prev & ~rx_s;
  assign start_c = (state == S_IDLE) && rxEn && fall;

  // Free-running 16x tick; phase re-aligned to each accepted start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      s_cnt   <= '0;
    end else if (start_c) begin
      div_cnt <= '0;
      s_cnt   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      s_cnt   <= s_next;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick    = (div_cnt == DIV_W'(DIV_EFF - 1));
  assign s_next  = s_cnt + 4'd1;
  assign mid     = tick && (s_next == 4'd9);
  assign bit_end = tick && (s_next == 4'd0);
  assign maj     = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);

  assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign par_exp   = (^shreg) ^ (PARITY == 32'd2);
  assign frm_fin   = frm_err | ~maj;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; rxEn low forces idle from anywhere
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (fall) state_next = S_START;
      S_START: begin
        if (mid && maj)   state_next = S_IDLE;
        else if (bit_end) state_next = S_DATA;
      end
      S_DATA:      if (bit_end && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_end) state_next = S_STOP;
      S_STOP:      if (mid && last_stop) state_next = frm_fin ? S_WAIT_IDLE : S_IDLE;
      S_WAIT_IDLE: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (!rxEn) state_next = S_IDLE;
  end

  // Output decode: next values for the registered busy/done flags
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    if (rxEn) begin
      case (state)
        S_START:          busy_c = rxBusy | (mid & ~maj);
        S_DATA, S_PARITY: busy_c = 1'b1;
        S_STOP: begin
          done_c = mid & last_stop;
          busy_c = ~done_c;
        end
        default: ;
      endcase
    end
  end

  // Datapath: samples, shift register, error flags and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp       <= 2'b11;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      rxBusy     <= 1'b0;
      rxDone     <= 1'b0;
      rxErr      <= 1'b0;
      rxParErr   <= 1'b0;
      rxFrameErr <= 1'b0;
      rxBreak    <= 1'b0;
      rxOut      <= '0;
    end else begin
      if (tick && (s_next == 4'd7 || s_next == 4'd8)) samp <= {samp[0], rx_s};

      if (state_next != state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + BIT_W'(1);

      if (start_c) begin
        par_bit <= 1'b0;
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end else if (mid) begin
        case (state)
          S_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
          S_PARITY: begin
            par_bit <= maj;
            par_err <= maj ^ par_exp;
          end
          S_STOP:   if (!maj) frm_err <= 1'b1;
          default: ;
        endcase
      end

      rxBusy <= busy_c;
      rxDone <= done_c;
      if (done_c) begin
        rxOut      <= shreg;
        rxParErr   <= par_err;
        rxFrameErr <= frm_fin;
        rxBreak    <= (shreg == '0) && !par_bit && frm_fin;
        rxErr      <= par_err | frm_fin;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: 8N1 @ 12 MHz, 8E1 and 7N2 on a faster divider.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int BIT0   = 1248;   // 16 * 78
  localparam int DIV0   = 78;
  localparam int BITF   = 128;    // 16 * 8
  localparam int CLKF   = 1228800;

  logic clk = 1'b0;
  logic reset, rxEn, rx0, rx1, rx2;
  logic rxBusy0, rxDone0, rxErr0, rxParErr0, rxFrameErr0, rxBreak0;
  logic rxBusy1, rxDone1, rxErr1, rxParErr1, rxFrameErr1, rxBreak1;
  logic rxBusy2, rxDone2, rxErr2, rxParErr2, rxFrameErr2, rxBreak2;
  logic [7:0] rxOut0, rxOut1;
  logic [6:0] rxOut2;

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(rx0),
    .rxBusy(rxBusy0), .rxDone(rxDone0), .rxErr(rxErr0), .rxParErr(rxParErr0),
    .rxFrameErr(rxFrameErr0), .rxBreak(rxBreak0), .rxOut(rxOut0));

  uart_rx_cfg #(.CLOCK_RATE(CLKF), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(rx1),
    .rxBusy(rxBusy1), .rxDone(rxDone1), .rxErr(rxErr1), .rxParErr(rxParErr1),
    .rxFrameErr(rxFrameErr1), .rxBreak(rxBreak1), .rxOut(rxOut1));

  uart_rx_cfg #(.CLOCK_RATE(CLKF), .DATA_BITS(7), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(rx2),
    .rxBusy(rxBusy2), .rxDone(rxDone2), .rxErr(rxErr2), .rxParErr(rxParErr2),
    .rxFrameErr(rxFrameErr2), .rxBreak(rxBreak2), .rxOut(rxOut2));

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       frm;
    logic       brk;
    logic       err;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   glitch_win = 1'b0;
  bit   busy_seen  = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_frame(string tag, exp_t e, logic [8:0] d, logic p, logic f,
                             logic b, logic r);
    check({tag, " rxOut"},      32'(d), 32'(e.data));
    check({tag, " rxParErr"},   32'(p), 32'(e.par));
    check({tag, " rxFrameErr"}, 32'(f), 32'(e.frm));
    check({tag, " rxBreak"},    32'(b), 32'(e.brk));
    check({tag, " rxErr"},      32'(r), 32'(e.err));
  endtask

  // Monitors: every rxDone pops one expected frame
  always @(negedge clk) begin
    if (rxDone0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL u0 unexpected rxDone: rxOut=0x%0h, expected no frame", rxOut0);
      end else begin
        e0 = q0.pop_front();
        check_frame("u0", e0, 9'(rxOut0), rxParErr0, rxFrameErr0, rxBreak0, rxErr0);
      end
    end
    if (glitch_win && rxBusy0) busy_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (rxDone1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL u1 unexpected rxDone: rxOut=0x%0h, expected no frame", rxOut1);
      end else begin
        e1 = q1.pop_front();
        check_frame("u1", e1, 9'(rxOut1), rxParErr1, rxFrameErr1, rxBreak1, rxErr1);
      end
    end
  end

  always @(negedge clk) begin
    if (rxDone2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL u2 unexpected rxDone: rxOut=0x%0h, expected no frame", rxOut2);
      end else begin
        e2 = q2.pop_front();
        check_frame("u2", e2, 9'(rxOut2), rxParErr2, rxFrameErr2, rxBreak2, rxErr2);
      end
    end
  end

  task automatic drive(int inst, logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  function automatic int qsize(int inst);
    case (inst)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Bit vector on the wire, bit 0 = start bit
  function automatic logic [15:0] mk_frame(logic [8:0] d, int nd, bit has_par, logic pb,
                                          logic s1, logic s2);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin
      f[k] = d[i];
      k++;
    end
    if (has_par) begin
      f[k] = pb;
      k++;
    end
    f[k] = s1;
    f[k+1] = s2;
    return f;
  endfunction

  task automatic send(int inst, logic [15:0] f, int n, int bitclk, bit chk_busy);
    for (int i = 0; i < n; i++) begin
      drive(inst, f[i]);
      if (chk_busy && i == 4) begin
        repeat (bitclk / 2) @(negedge clk);
        check("u0 rxBusy mid-frame", 32'(rxBusy0), 32'd1);
        repeat (bitclk - bitclk / 2) @(negedge clk);
      end else begin
        repeat (bitclk) @(negedge clk);
      end
    end
  endtask

  task automatic idle(int inst, int clks);
    drive(inst, 1'b1);
    repeat (clks) @(negedge clk);
  endtask

  task automatic drain(string name, int inst, int bound);
    int t;
    t = 0;
    while (qsize(inst) != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    check({name, " frames outstanding"}, 32'(qsize(inst)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rxEn = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rxBusy", 32'(rxBusy0), 32'd0);
    check("reset rxDone", 32'(rxDone0), 32'd0);
    check("reset rxErr",  32'(rxErr0),  32'd0);
    check("reset rxOut",  32'(rxOut0),  32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 good frame 0x35
    q0.push_back('{data: 9'h035, par: 1'b0, frm: 1'b0, brk: 1'b0, err: 1'b0});
    send(0, mk_frame(9'h035, 8, 1'b0, 1'b0, 1'b1, 1'b1), 10, BIT0, 1'b1);
    idle(0, 100);
    drain("t1", 0, 2 * BIT0);

    // Line low for two frames: one break report, then nothing until a new start
    q0.push_back('{data: 9'h000, par: 1'b0, frm: 1'b1, brk: 1'b1, err: 1'b1});
    drive(0, 1'b0);
    repeat (20 * BIT0) @(negedge clk);
    idle(0, 2 * BIT0);
    drain("t4", 0, BIT0);

    // Short low glitch is rejected, next frame still received
    glitch_win = 1'b1;
    drive(0, 1'b0);
    repeat (3 * DIV0) @(negedge clk);
    drive(0, 1'b1);
    repeat (30 * DIV0) @(negedge clk);
    glitch_win = 1'b0;
    check("glitch rxBusy asserted", 32'(busy_seen), 32'd0);
    q0.push_back('{data: 9'h0A5, par: 1'b0, frm: 1'b0, brk: 1'b0, err: 1'b0});
    send(0, mk_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1), 10, BIT0, 1'b0);
    idle(0, 100);
    drain("t3", 0, 2 * BIT0);

    // 8E1: 0x35 has even weight, so a parity bit of 1 is wrong
    q1.push_back('{data: 9'h035, par: 1'b1, frm: 1'b0, brk: 1'b0, err: 1'b1});
    send(1, mk_frame(9'h035, 8, 1'b1, 1'b1, 1'b1, 1'b1), 11, BITF, 1'b0);
    idle(1, 50);
    drain("t2 bad parity", 1, 2 * BITF);
    q1.push_back('{data: 9'h035, par: 1'b0, frm: 1'b0, brk: 1'b0, err: 1'b0});
    send(1, mk_frame(9'h035, 8, 1'b1, 1'b0, 1'b1, 1'b1), 11, BITF, 1'b0);
    idle(1, 50);
    drain("t2 good parity", 1, 2 * BITF);

    // 7N2: second stop low, then back-to-back frames
    q2.push_back('{data: 9'h05A, par: 1'b0, frm: 1'b1, brk: 1'b0, err: 1'b1});
    send(2, mk_frame(9'h05A, 7, 1'b0, 1'b0, 1'b1, 1'b0), 10, BITF, 1'b0);
    idle(2, 3 * BITF);
    drain("t5 stop2", 2, 2 * BITF);
    q2.push_back('{data: 9'h011, par: 1'b0, frm: 1'b0, brk: 1'b0, err: 1'b0});
    q2.push_back('{data: 9'h022, par: 1'b0, frm: 1'b0, brk: 1'b0, err: 1'b0});
    send(2, mk_frame(9'h011, 7, 1'b0, 1'b0, 1'b1, 1'b1), 10, BITF, 1'b0);
    send(2, mk_frame(9'h022, 7, 1'b0, 1'b0, 1'b1, 1'b1), 10, BITF, 1'b0);
    idle(2, BITF);
    drain("t5 back-to-back", 2, 2 * BITF);

    // Abort with rxEn after data bit 3
    send(0, mk_frame(9'h00F, 8, 1'b0, 1'b0, 1'b1, 1'b1), 5, BIT0, 1'b0);
    check("abort rxBusy before", 32'(rxBusy0), 32'd1);
    rxEn = 1'b0;
    @(negedge clk);
    check("abort rxBusy after 1 clk", 32'(rxBusy0), 32'd0);
    idle(0, 100);
    rxEn = 1'b1;
    idle(0, 2 * BIT0);
    check("abort rxOut held", 32'(rxOut0), 32'h0A5);

    // Reset mid-frame clears outputs at once
    send(0, mk_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1), 4, BIT0, 1'b0);
    check("pre-reset rxBusy", 32'(rxBusy0), 32'd1);
    reset = 1'b0;
    #1;
    check("mid reset rxBusy",     32'(rxBusy0),     32'd0);
    check("mid reset rxOut",      32'(rxOut0),      32'd0);
    check("mid reset rxDone",     32'(rxDone0),     32'd0);
    check("mid reset rxFrameErr", 32'(rxFrameErr0), 32'd0);
    check("mid reset rxBreak",    32'(rxBreak0),    32'd0);
    @(negedge clk);
    drive(0, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    check("end u0 queue", 32'(q0.size()), 32'd0);
    check("end u1 queue", 32'(q1.size()), 32'd0);
    check("end u2 queue", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
